loadstore_unit: RTL and testbench
=================================

# loadstore_unit

Load/store unit for the MIPS datapath: it accepts byte, halfword and word load/store requests from the pipeline, checks alignment and range, and drives the word-addressed data memory port. Sub-word stores run as a read-modify-write. Loads are sign- or zero-extended. It sits between the pipeline MEM stage and the data memory, and signals completion with a one-cycle response pulse.

## Interface
- ADDR_W, 10, word-address width of the data memory; valid byte range is 0 .. 4·2^ADDR_W−1
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; transfer when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data; byte/half stores use the low bits
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected; valid with rsp_valid
- mem_readMem  out  1  memory read enable
- mem_writeMem  out  1  memory write enable, sampled on clk
- mem_R_addr  out  ADDR_W  read word address
- mem_W_addr  out  ADDR_W  write word address
- mem_W_data  out  32  write data
- mem_R_data  in  32  combinational read data; high-Z when mem_readMem = 0

## Operation
- The FSM has five states: IDLE, READ, WRITE, RESP, ERR.
- **IDLE**
  - req_ready = 1. No other state asserts req_ready.
  - On transfer, capture we, size, signed, addr[1:0], word address addr[ADDR_W+1:2] and wdata.
- **Error check at accept**
  - An error is any of: size = 11; size = 01 with addr[0] ≠ 0; size = 10 with addr[1:0] ≠ 0; addr[31:ADDR_W+2] ≠ 0.
  - On error, go to ERR. No memory enable is ever asserted for that request.
- **Next state at accept (no error)**
  - Load → READ.
  - Word store → WRITE, with merged data = wdata.
  - Byte or half store → READ.
- **READ**
  - mem_readMem = 1 and mem_R_addr = captured word address.
  - mem_R_data is sampled at the end of the cycle.
  - Load: extract the lane, extend it, register it into rsp_rdata, then go to RESP.
  - Sub-word store: merge the new lane into the sampled word, register the result as W_data, then go to WRITE.
- **Lane mapping (little-endian)**
  - Byte k (k = addr[1:0]) occupies bits 8k+7:8k.
  - Half h (h = addr[1]) occupies bits 16h+15:16h.
  - Word loads ignore req_signed.
- **WRITE**
  - mem_writeMem = 1 for exactly this one cycle.
  - mem_W_addr = captured word address, mem_W_data = merged word.
  - Next state is RESP.
- **RESP**
  - rsp_valid = 1 and rsp_err = 0; next state is IDLE.
- **ERR**
  - rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; next state is IDLE.
- **Output behaviour outside active states**
  - mem_readMem and mem_writeMem are 0 in every state other than READ and WRITE respectively.
  - mem_R_addr and mem_W_addr always show the captured word-address register.
  - rsp_rdata and rsp_err are 0 whenever rsp_valid = 0.
- **Back-pressure**
  - There is no response back-pressure; the pipeline stalls on !req_ready.

## Timing
- **Reset state** (rst = 0, asynchronous): state = IDLE; req_ready = 1.
  - Zero: rsp_valid, rsp_err, rsp_rdata, mem_readMem, mem_writeMem, mem_R_addr, mem_W_addr, mem_W_data, all capture registers.
- **Latency**, accept in cycle T:
  - Error: rsp_valid in T+1.
  - Load: READ in T+1, rsp_valid in T+2.
  - Word store: WRITE in T+1, rsp_valid in T+2.
  - Sub-word store: READ in T+1, WRITE in T+2, rsp_valid in T+3.
- **Throughput:** the next request is accepted no earlier than the cycle after RESP or ERR. req_valid held high is accepted exactly once per accept cycle.
- **Reset mid-operation:**
  - The transaction is dropped: no further memory enable and no rsp_valid.
  - A write already clocked before reset stands; a write not yet clocked never occurs.
- **Input stability:** request inputs are sampled only on the accept edge and may change afterwards.
- **Range edge:** byte 4·2^ADDR_W−1 (0xFFF at default) is legal; 0x1000 is an error.

## Test plan
Memory is preloaded with word 5 = 0x8899AABB (byte address 0x14). T is the accept cycle.

1. lw 0x14 → rsp_valid at T+2 with rsp_rdata = 0x8899AABB and rsp_err = 0. mem_readMem is high only in T+1, with mem_R_addr = 5.
2. Sub-word loads:
   - lb signed 0x17 → 0xFFFFFF88.
   - lbu 0x15 → 0x000000AA.
   - lh signed 0x14 → 0xFFFFAABB.
   - lhu 0x16 → 0x00008899.
3. sb 0x16 with wdata 0x12345677 → READ in T+1, mem_writeMem high only in T+2 with W_addr = 5 and W_data = 0x8877AABB, rsp_valid at T+3. A follow-up lw 0x14 returns 0x8877AABB.
4. Error requests, each giving rsp_err = 1 at T+1 with no read/write enable and memory unchanged:
   - lw 0x16 (misaligned).
   - lh 0x15 (misaligned).
   - lb 0x1000 (out of range).
   - size = 11 (reserved).
5. sh 0x14 with rst pulsed low during its READ cycle → no mem_writeMem, no rsp_valid, all outputs at reset values. After release, req_ready = 1 and word 5 is still 0x8899AABB.
6. req_valid held high for a lw followed by a word store → req_ready is low for T+1..T+2, the second request is accepted at T+3, and each request produces exactly one rsp_valid.

Source files
------------

// File: rtl/loadstore_unit_if.sv
// Pipeline request/response and data-memory port bundle
// for the load/store unit; slave = the unit, master = its environment.
interface loadstore_unit_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_readMem;
  logic              mem_writeMem;
  logic [ADDR_W-1:0] mem_R_addr;
  logic [ADDR_W-1:0] mem_W_addr;
  logic [31:0]       mem_W_data;
  logic [31:0]       mem_R_data;

  modport slave (
    input  req_valid, req_we, req_size, req_signed,
    input  req_addr, req_wdata, mem_R_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_readMem, mem_writeMem, mem_R_addr,
    output mem_W_addr, mem_W_data
  );

  modport master (
    output req_valid, req_we, req_size, req_signed,
    output req_addr, req_wdata, mem_R_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_readMem, mem_writeMem, mem_R_addr,
    input  mem_W_addr, mem_W_data
  );
endinterface

// File: rtl/loadstore_unit.sv
// Load/store unit: byte/half/word access to a word-addressed memory,
// sub-word stores by read-modify-write. Ports: clk, rst (async low), bus.
module loadstore_unit #(
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  loadstore_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, READ, WRITE, RESP, ERR
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       rd_q, rd_d;

  logic        accept;
  logic        bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = bus.req_valid && (state_q == IDLE);

  assign bad =
      (bus.req_size == 2'b11)
    || ((bus.req_size == 2'b01) && bus.req_addr[0])
    || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
    || (|bus.req_addr[31:ADDR_W+2]);

  assign lane_b = bus.mem_R_data[{off_q, 3'b000} +: 8];
  assign lane_h = bus.mem_R_data[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = bus.mem_R_data;
    unique case (1'b1)
      size_q == 2'b00:
        load_val = {{24{sgn_q & lane_b[7]}}, lane_b};
      size_q == 2'b01:
        load_val = {{16{sgn_q & lane_h[15]}}, lane_h};
      default:
        load_val = bus.mem_R_data;
    endcase
  end

  // New lane overlays the word just read.
  always_comb begin
    merged = bus.mem_R_data;
    unique case (1'b1)
      size_q == 2'b00:
        merged[{off_q, 3'b000} +: 8] = wd_q[7:0];
      size_q == 2'b01:
        merged[{off_q[1], 4'b0000} +: 16] = wd_q[15:0];
      default:
        merged = wd_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d   = bus.req_we;
          size_d = bus.req_size;
          sgn_d  = bus.req_signed;
          off_d  = bus.req_addr[1:0];
          wa_d   = bus.req_addr[ADDR_W+1:2];
          wd_d   = bus.req_wdata;
          rd_d   = '0;
          unique case (1'b1)
            bad:
              state_d = ERR;
            bus.req_we && (bus.req_size == 2'b10):
              state_d = WRITE;
            default:
              state_d = READ;
          endcase
        end
      end
      READ: begin
        if (we_q) begin
          wd_d    = merged;
          state_d = WRITE;
        end else begin
          rd_d    = load_val;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q   <= 1'b0;
      size_q <= 2'b00;
      sgn_q  <= 1'b0;
      off_q  <= 2'b00;
      wa_q   <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
    end else begin
      we_q   <= we_d;
      size_q <= size_d;
      sgn_q  <= sgn_d;
      off_q  <= off_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      rd_q   <= rd_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.mem_readMem  = (state_q == READ);
  assign bus.mem_writeMem = (state_q == WRITE);
  assign bus.mem_R_addr   = wa_q;
  assign bus.mem_W_addr   = wa_q;
  assign bus.mem_W_data   = wd_q;
  assign bus.rsp_valid    = (state_q == RESP)
                         || (state_q == ERR);
  assign bus.rsp_err      = (state_q == ERR);
  assign bus.rsp_rdata    = (state_q == RESP)
                         ? rd_q : 32'h0;

endmodule

// File: tb/tb_loadstore_unit.sv
// Self-checking bench for loadstore_unit: vector table plus
// reset-mid-op and back-to-back handshake sequences.
module tb_loadstore_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] mem [0:1023];

  loadstore_unit_if #(.ADDR_W(10)) bus ();

  loadstore_unit #(.ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_R_data = bus.mem_readMem
                        ? mem[bus.mem_R_addr] : 32'bz;

  always @(posedge clk)
    if (bus.mem_writeMem)
      mem[bus.mem_W_addr] <= bus.mem_W_data;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_wr;
    logic [9:0]  exp_wa;
    logic [31:0] exp_wd;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic we, input logic [1:0] size,
    input logic sgn, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] rdata,
    input logic err, input int lat,
    input logic [7:0] rd, input logic [7:0] wr,
    input logic [9:0] wa, input logic [31:0] wd);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn;
    v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_err = err;
    v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
    v.exp_wa = wa; v.exp_wd = wd;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic [7:0]  rdm, wrm;
    logic [31:0] rdata, wd;
    logic [9:0]  wa;
    logic        err, quiet_bad;
    int          lat, npulse;
    v = vecs[i];
    @(negedge clk);
    bus.req_we     = v.we;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_valid  = 1'b1;
    chk($sformatf("v%0d ready", i), {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.req_wdata = 32'hA5A5A5A5;
    bus.req_addr  = 32'hFFFFFFFF;
    rdm = '0; wrm = '0; rdata = '0; wd = '0; wa = '0;
    err = 1'b0; quiet_bad = 1'b0; lat = 0; npulse = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.mem_readMem) rdm[c] = 1'b1;
      if (bus.mem_writeMem) begin
        wrm[c] = 1'b1;
        wa = bus.mem_W_addr;
        wd = bus.mem_W_data;
      end
      if (bus.rsp_valid) begin
        npulse++;
        if (lat == 0) begin
          lat   = c;
          rdata = bus.rsp_rdata;
          err   = bus.rsp_err;
        end
      end else if (bus.rsp_err || bus.rsp_rdata != 0) begin
        quiet_bad = 1'b1;
      end
    end
    chk($sformatf("v%0d lat", i), lat, v.exp_lat);
    chk($sformatf("v%0d pulses", i), npulse, 1);
    chk($sformatf("v%0d rdata", i), rdata, v.exp_rdata);
    chk($sformatf("v%0d err", i), {31'b0, err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d rdmask", i), {24'b0, rdm}, {24'b0, v.exp_rd});
    chk($sformatf("v%0d wrmask", i), {24'b0, wrm}, {24'b0, v.exp_wr});
    chk($sformatf("v%0d quiet", i), {31'b0, quiet_bad}, 32'd0);
    if (v.exp_wr != 0) begin
      chk($sformatf("v%0d waddr", i), {22'b0, wa}, {22'b0, v.exp_wa});
      chk($sformatf("v%0d wdata", i), wd, v.exp_wd);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ready"}, {31'b0, bus.req_ready}, 32'd1);
    chk({tag, " rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
    chk({tag, " rsp_err"}, {31'b0, bus.rsp_err}, 32'd0);
    chk({tag, " rsp_rdata"}, bus.rsp_rdata, 32'd0);
    chk({tag, " readMem"}, {31'b0, bus.mem_readMem}, 32'd0);
    chk({tag, " writeMem"}, {31'b0, bus.mem_writeMem}, 32'd0);
    chk({tag, " R_addr"}, {22'b0, bus.mem_R_addr}, 32'd0);
    chk({tag, " W_addr"}, {22'b0, bus.mem_W_addr}, 32'd0);
    chk({tag, " W_data"}, bus.mem_W_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  rdy_m, rsp_m;
    logic [31:0] first_rd;
    int          nwr, nrsp;
    checks = 0;
    errors = 0;
    for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
    mem[5]    = 32'h8899AABB;
    mem[1023] = 32'h80123456;

    vecs[0]  = mk(0, 2'b10, 0, 32'h14, 0, 32'h8899AABB, 0, 2, 8'h02, 8'h00, 0, 0);
    vecs[1]  = mk(0, 2'b00, 1, 32'h17, 0, 32'hFFFFFF88, 0, 2, 8'h02, 8'h00, 0, 0);
    vecs[2]  = mk(0, 2'b00, 0, 32'h15, 0, 32'h000000AA, 0, 2, 8'h02, 8'h00, 0, 0);
    vecs[3]  = mk(0, 2'b01, 1, 32'h14, 0, 32'hFFFFAABB, 0, 2, 8'h02, 8'h00, 0, 0);
    vecs[4]  = mk(0, 2'b01, 0, 32'h16, 0, 32'h00008899, 0, 2, 8'h02, 8'h00, 0, 0);
    vecs[5]  = mk(1, 2'b00, 0, 32'h16, 32'h12345677, 0, 0, 3, 8'h02, 8'h04, 10'd5, 32'h8877AABB);
    vecs[6]  = mk(0, 2'b10, 0, 32'h14, 0, 32'h8877AABB, 0, 2, 8'h02, 8'h00, 0, 0);
    vecs[7]  = mk(0, 2'b10, 0, 32'h16, 0, 0, 1, 1, 8'h00, 8'h00, 0, 0);
    vecs[8]  = mk(0, 2'b01, 1, 32'h15, 0, 0, 1, 1, 8'h00, 8'h00, 0, 0);
    vecs[9]  = mk(0, 2'b00, 1, 32'h1000, 0, 0, 1, 1, 8'h00, 8'h00, 0, 0);
    vecs[10] = mk(1, 2'b11, 0, 32'h14, 32'hFFFFFFFF, 0, 1, 1, 8'h00, 8'h00, 0, 0);
    vecs[11] = mk(0, 2'b00, 1, 32'hFFF, 0, 32'hFFFFFF80, 0, 2, 8'h02, 8'h00, 0, 0);
    vecs[12] = mk(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 0, 0, 2, 8'h00, 8'h02, 10'd8, 32'hDEADBEEF);
    vecs[13] = mk(0, 2'b10, 1, 32'h20, 0, 32'hDEADBEEF, 0, 2, 8'h02, 8'h00, 0, 0);
    vecs[14] = mk(1, 2'b01, 0, 32'h1E, 32'hCAFEF00D, 0, 0, 3, 8'h02, 8'h04, 10'd7, 32'hF00D0000);
    vecs[15] = mk(0, 2'b01, 1, 32'h1E, 0, 32'hFFFFF00D, 0, 2, 8'h02, 8'h00, 0, 0);
    vecs[16] = mk(0, 2'b01, 0, 32'h1E, 0, 32'h0000F00D, 0, 2, 8'h02, 8'h00, 0, 0);
    vecs[17] = mk(1, 2'b10, 0, 32'h14, 32'h8899AABB, 0, 0, 2, 8'h00, 8'h02, 10'd5, 32'h8899AABB);

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(i);
      if (i == 10) begin
        chk("err mem5", mem[5], 32'h8877AABB);
        chk("err mem0", mem[0], 32'h0);
      end
    end

    // sh dropped by reset during its READ cycle
    @(negedge clk);
    bus.req_we     = 1'b1;
    bus.req_size   = 2'b01;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h14;
    bus.req_wdata  = 32'h00001111;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst read", {31'b0, bus.mem_readMem}, 32'd1);
    #1 rst = 1'b0;
    #1 chk_reset_outputs("midrst");
    #1 rst = 1'b1;
    nwr = 0;
    nrsp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.mem_writeMem) nwr++;
      if (bus.rsp_valid) nrsp++;
    end
    chk("rst writes", nwr, 0);
    chk("rst rsps", nrsp, 0);
    chk("rst ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst mem5", mem[5], 32'h8899AABB);

    // held req_valid: lw then sw back to back
    @(negedge clk);
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h14;
    bus.req_wdata  = 32'h0;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h24;
    bus.req_wdata = 32'h55AA55AA;
    rdy_m = '0;
    rsp_m = '0;
    first_rd = '0;
    nwr = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (bus.req_ready) rdy_m[c] = 1'b1;
      if (bus.mem_writeMem) nwr++;
      if (bus.rsp_valid) begin
        if (rsp_m == 0) first_rd = bus.rsp_rdata;
        rsp_m[c] = 1'b1;
      end
      if (c == 3) begin
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
      end
    end
    chk("b2b ready", {24'b0, rdy_m}, 32'h000000C8);
    chk("b2b rsp", {24'b0, rsp_m}, 32'h00000024);
    chk("b2b rdata", first_rd, 32'h8899AABB);
    chk("b2b writes", nwr, 1);
    chk("b2b mem9", mem[9], 32'h55AA55AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
